// File: rtl/motor_cmd_queue_pkg.sv
// Shared definitions for the motor command queue: motor/position widths and
// the issue FSM encoding used by the queue and its FIFO.
package motor_cmd_queue_pkg;

  localparam int NUM_MOTORS = 6;
  localparam int MOTOR_W    = 3;
  localparam int POS_W      = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOCK,
    RELEASE,
    WAIT_DONE
  } issue_state_t;

  function automatic logic motor_valid(input logic [MOTOR_W-1:0] motor);
    return motor < MOTOR_W'(NUM_MOTORS);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO holding (motor, position) pairs; a push into a full FIFO is
// only taken when the head leaves in the same cycle.
module cmd_fifo
  import motor_cmd_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [MOTOR_W-1:0]       wr_motor,
  input  logic [POS_W-1:0]         wr_value,
  output logic [MOTOR_W-1:0]       rd_motor,
  output logic [POS_W-1:0]         rd_value,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [MOTOR_W-1:0] mem_motor [DEPTH];
  logic [POS_W-1:0]   mem_value [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               wr_en;
  logic               rd_en;

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign rd_motor = mem_motor[rd_ptr];
  assign rd_value = mem_value[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_motor[wr_ptr] <= wr_motor;
      mem_value[wr_ptr] <= wr_value;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/motor_cmd_queue.sv
// Queues motor position commands and hands them to Control one at a time,
// pulsing InputLock and then waiting for the pulse generator to finish.
module motor_cmd_queue
  import motor_cmd_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int LOCK_CYCLES = 4,
  parameter int BUSY_WAIT   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MOTOR_W-1:0]     InMotor,
  input  logic [POS_W-1:0]       InValue,
  input  logic                   InStrobe,
  input  logic                   Busy,
  output logic [MOTOR_W-1:0]     Motor,
  output logic [POS_W-1:0]       Value,
  output logic                   InputLock,
  output logic                   Full,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Drop
);

  localparam int CNT_MAX = (LOCK_CYCLES > BUSY_WAIT) ? LOCK_CYCLES : BUSY_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  issue_state_t       state;
  issue_state_t       next_state;
  logic [CNT_W-1:0]   cnt;
  logic               pop;
  logic               push;
  logic               cmd_ok;
  logic [MOTOR_W-1:0] head_motor;
  logic [POS_W-1:0]   head_value;

  assign cmd_ok = motor_valid(InMotor);
  assign push   = InStrobe && cmd_ok;

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_motor (InMotor),
    .wr_value (InValue),
    .rd_motor (head_motor),
    .rd_value (head_value),
    .full     (Full),
    .empty    (Empty),
    .count    (Count)
  );

  always_comb begin
    next_state = state;
    InputLock  = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!Empty && !Busy) next_state = SETUP;
      end
      SETUP: begin
        next_state = LOCK;
      end
      LOCK: begin
        InputLock = 1'b1;
        if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
          pop        = 1'b1;
          next_state = RELEASE;
        end
      end
      RELEASE: begin
        if (Busy)                                  next_state = WAIT_DONE;
        else if (cnt == CNT_W'(BUSY_WAIT - 1))     next_state = IDLE;
      end
      WAIT_DONE: begin
        if (!Busy) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // cnt measures time spent in the current state; it restarts on every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
    end
  end

  // Motor/Value are captured on entry to SETUP and held until the next issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Motor <= '0;
      Value <= '0;
      Drop  <= 1'b0;
    end else begin
      if (state == IDLE && next_state == SETUP) begin
        Motor <= head_motor;
        Value <= head_value;
      end
      Drop <= InStrobe && (!cmd_ok || (Full && !pop));
    end
  end

endmodule

// File: tb/tb_motor_cmd_queue.sv
// Randomized self-checking bench: a queue-based reference model predicts every
// output each cycle while a small Busy generator imitates the pulse generator.
module tb_motor_cmd_queue;

  localparam int DEPTH       = 4;
  localparam int LOCK_CYCLES = 4;
  localparam int BUSY_WAIT   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] InMotor = '0;
  logic [9:0] InValue = '0;
  logic       InStrobe = 1'b0;
  logic       Busy = 1'b0;
  logic [2:0] Motor;
  logic [9:0] Value;
  logic       InputLock;
  logic       Full;
  logic       Empty;
  logic [2:0] Count;
  logic       Drop;

  always #5 clk = ~clk;

  motor_cmd_queue #(
    .DEPTH       (DEPTH),
    .LOCK_CYCLES (LOCK_CYCLES),
    .BUSY_WAIT   (BUSY_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .InMotor   (InMotor),
    .InValue   (InValue),
    .InStrobe  (InStrobe),
    .Busy      (Busy),
    .Motor     (Motor),
    .Value     (Value),
    .InputLock (InputLock),
    .Full      (Full),
    .Empty     (Empty),
    .Count     (Count),
    .Drop      (Drop)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pending commands plus the age of the command in flight
  // (-1 none, 0 setup, 1..LOCK_CYCLES locked, beyond that awaiting Busy).
  int q_m[$];
  int q_v[$];
  int age = -1;
  bit seen_busy = 0;
  int cur_m = 0;
  int cur_v = 0;
  bit exp_drop = 0;

  bit force_busy = 0;
  int sched_mode = 0;
  int fixed_len = 10;
  int bw_delay = -1;
  int bw_len = 0;
  bit prev_lock = 0;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit expLock();
    return (age >= 1) && (age <= LOCK_CYCLES);
  endfunction

  task automatic modelClear();
    q_m.delete();
    q_v.delete();
    age = -1;
    seen_busy = 0;
    cur_m = 0;
    cur_v = 0;
    exp_drop = 0;
    bw_delay = -1;
    bw_len = 0;
    prev_lock = 0;
  endtask

  task automatic modelStep(input bit strobe, input int m, input int v, input bit busy);
    bit leaving;
    bit ok;
    leaving = (age == LOCK_CYCLES);
    ok = strobe && (m <= 5) && ((q_m.size() < DEPTH) || leaving);
    exp_drop = strobe && !ok;
    if (age < 0) begin
      if (q_m.size() > 0 && !busy) begin
        age = 0;
        cur_m = q_m[0];
        cur_v = q_v[0];
      end
    end else if (age <= LOCK_CYCLES) begin
      if (leaving) begin
        void'(q_m.pop_front());
        void'(q_v.pop_front());
      end
      age++;
    end else if (!seen_busy) begin
      if (busy) seen_busy = 1;
      else if (age == LOCK_CYCLES + BUSY_WAIT) age = -1;
      else age++;
    end else if (!busy) begin
      age = -1;
      seen_busy = 0;
    end
    if (ok) begin
      q_m.push_back(m);
      q_v.push_back(v);
    end
  endtask

  task automatic checkAll();
    checkOutput("InputLock", InputLock, expLock());
    checkOutput("Motor", Motor, cur_m);
    checkOutput("Value", Value, cur_v);
    checkOutput("Count", Count, q_m.size());
    checkOutput("Empty", Empty, q_m.size() == 0);
    checkOutput("Full", Full, q_m.size() == DEPTH);
    checkOutput("Drop", Drop, exp_drop);
  endtask

  // Pulse generator stand-in: after each InputLock fall it may emit a Busy pulse.
  task automatic updateBusy();
    bit lk;
    lk = expLock();
    if (prev_lock && !lk) begin
      if (sched_mode == 1) begin
        bw_delay = 1;
        bw_len = fixed_len;
      end else if (sched_mode == 0 && $urandom_range(0, 3) != 0) begin
        bw_delay = $urandom_range(0, 5);
        bw_len = $urandom_range(1, 25);
      end
    end
    prev_lock = lk;
    if (force_busy) Busy = 1'b1;
    else if (bw_delay > 0) begin
      bw_delay--;
      Busy = 1'b0;
    end else if (bw_delay == 0 && bw_len > 0) begin
      Busy = 1'b1;
      bw_len--;
      if (bw_len == 0) bw_delay = -1;
    end else Busy = 1'b0;
  endtask

  task automatic applyStimulus(input bit strobe, input int m, input int v);
    InStrobe = strobe;
    InMotor = 3'(m);
    InValue = 10'(v);
    @(posedge clk);
    modelStep(strobe, m, v, Busy);
    @(negedge clk);
    checkAll();
    updateBusy();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    InStrobe = 1'b0;
    force_busy = 0;
    Busy = 1'b0;
    modelClear();
    repeat (2) @(negedge clk);
    checkAll();
    rst = 1'b0;
  endtask

  initial begin
    bit reached;
    resetDut();

    sched_mode = 1;
    fixed_len = 70;
    applyStimulus(1, 2, 7);
    idleCycles(100);

    fixed_len = 10;
    applyStimulus(1, 0, 10);
    applyStimulus(1, 0, 5);
    idleCycles(60);

    force_busy = 1;
    Busy = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1, i, 100 + i);
    force_busy = 0;
    fixed_len = 5;
    idleCycles(150);

    applyStimulus(1, 7, 3);
    applyStimulus(1, 6, 9);
    idleCycles(10);

    sched_mode = 2;
    applyStimulus(1, 1, 0);
    applyStimulus(1, 3, 33);
    idleCycles(60);

    resetDut();
    sched_mode = 1;
    force_busy = 1;
    Busy = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1, i + 1, 200 + i);
    force_busy = 0;
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      applyStimulus(0, 0, 0);
      reached = (age == 2);
    end
    checkOutput("reach_lock", reached, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_InputLock", InputLock, 0);
    checkOutput("rst_Count", Count, 0);
    checkOutput("rst_Empty", Empty, 1);
    checkOutput("rst_Full", Full, 0);
    checkOutput("rst_Motor", Motor, 0);
    InStrobe = 1'b0;
    Busy = 1'b0;
    modelClear();
    @(negedge clk);
    rst = 1'b0;
    idleCycles(20);

    sched_mode = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        applyStimulus(1, $urandom_range(0, 7), $urandom_range(0, 1023));
      else
        applyStimulus(0, 0, 0);
    end
    sched_mode = 2;
    idleCycles(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
